qsys_system_timer_bank: RTL and testbench

QSYS_SYSTEM_TIMER_BANK -- requirements
Module: qsys_system_timer_bank

---
 rtl/qsys_system_timer_bank.sv | 221 ++++++++++++++++++++++
 tb/tb_qsys_system_timer_bank.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_system_timer_bank.sv
// qsys_system_timer_bank: bank of NUM_CH independent down-counting timers
// behind a 16-bit register slave interface. Each channel occupies eight
// register slots selected by address[2:0]; address[5:3] selects the channel.
// Optional feature macro: TIMER_BANK_PRESCALE_EN adds a per-channel 8-bit
// tick prescaler at register 7 (otherwise register 7 reads 0, writes ignored).
module qsys_system_timer_bank #(
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned RST_PERIOD = 49999999
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

    // Bits of the period / counter that live in the high register.
    localparam int unsigned     PH_W    = CNT_W - 16;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(RST_PERIOD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        REG_STATUS   = 3'd0,
        REG_CONTROL  = 3'd1,
        REG_PERIOD_L = 3'd2,
        REG_PERIOD_H = 3'd3,
        REG_SNAP_L   = 3'd4,
        REG_SNAP_H   = 3'd5,
        REG_PENDING  = 3'd6,
        REG_PRESCALE = 3'd7
    } reg_e;

    logic [2:0]        ch_sel;
    reg_e              reg_sel;
    logic              wr_en;
    logic [NUM_CH-1:0] irq_ch;
    logic [15:0]       rd_val [8];

    assign ch_sel  = address[5:3];
    assign reg_sel = reg_e'(address[2:0]);
    assign wr_en   = chipselect & ~write_n;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_nx;
        logic [CNT_W-1:0] period;
        logic [CNT_W-1:0] new_period;
        logic [CNT_W-1:0] snap;
        logic             run;
        logic             run_nx;
        logic             to;
        logic             to_nx;
        logic             ito;
        logic             cont;
        logic             ch_wr;
        logic             wr_status;
        logic             wr_control;
        logic             wr_pl;
        logic             wr_ph;
        logic             wr_snap;
        logic             start;
        logic             stop;
        logic             zero;
        logic             tick;
        logic             reload;
        logic [15:0]      rd;

        assign ch_wr      = wr_en && (ch_sel == 3'(g));
        assign wr_status  = ch_wr && (reg_sel == REG_STATUS);
        assign wr_control = ch_wr && (reg_sel == REG_CONTROL);
        assign wr_pl      = ch_wr && (reg_sel == REG_PERIOD_L);
        assign wr_ph      = ch_wr && (reg_sel == REG_PERIOD_H);
        assign wr_snap    = ch_wr && ((reg_sel == REG_SNAP_L) || (reg_sel == REG_SNAP_H));
        assign start      = writedata[2];
        assign stop       = writedata[3];
        assign zero       = (cnt == '0);

`ifdef TIMER_BANK_PRESCALE_EN
        logic       wr_pre;
        logic [7:0] prescale;
        logic [7:0] div;

        assign wr_pre = ch_wr && (reg_sel == REG_PRESCALE);
        assign tick   = run && (div == prescale);

        // Prescale register and tick divider; the divider restarts on START,
        // on every period reload, and whenever the channel is idle.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                prescale <= '0;
                div      <= '0;
            end else begin
                if (wr_pre) begin
                    prescale <= writedata[7:0];
                end
                if (!run || reload || tick || (wr_control && start)) begin
                    div <= '0;
                end else begin
                    div <= div + 8'd1;
                end
            end
        end
`else
        assign tick = run;
`endif

        // A counter reaching zero reloads on the next tick when continuous;
        // a one-shot reloads and stops right away so the counter rests at the period.
        assign reload = run && zero && (tick || !cont);

        // Period image after a write to either half, used to preload the counter.
        always_comb begin
            new_period = period;
            if (wr_pl) begin
                new_period[15:0] = writedata;
            end
            if (wr_ph) begin
                new_period[CNT_W-1:16] = writedata[PH_W-1:0];
            end
        end

        // Next counter, RUN and TO; TO marks the rising edge of counter==0 and
        // beats a simultaneous status-write clear.
        always_comb begin
            cnt_nx = cnt;
            run_nx = run;
            if (reload) begin
                cnt_nx = period;
                if (!cont) begin
                    run_nx = 1'b0;
                end
            end else if (tick && !zero) begin
                cnt_nx = cnt - CNT_ONE;
            end
            if (wr_control) begin
                if (start) begin
                    run_nx = 1'b1;
                end else if (stop) begin
                    run_nx = 1'b0;
                end
            end
            if (wr_pl || wr_ph) begin
                cnt_nx = new_period;
                run_nx = 1'b0;
            end
            to_nx = wr_status ? 1'b0 : to;
            if ((cnt_nx == '0) && !zero) begin
                to_nx = 1'b1;
            end
        end

        // Channel state registers.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                cnt    <= CNT_RST;
                period <= CNT_RST;
                snap   <= '0;
                run    <= 1'b0;
                to     <= 1'b0;
                ito    <= 1'b0;
                cont   <= 1'b0;
            end else begin
                cnt <= cnt_nx;
                run <= run_nx;
                to  <= to_nx;
                if (wr_pl || wr_ph) begin
                    period <= new_period;
                end
                if (wr_snap) begin
                    snap <= cnt;
                end
                if (wr_control) begin
                    ito  <= writedata[0];
                    cont <= writedata[1];
                end
            end
        end

        assign irq_ch[g] = to & ito;

        // Read view of this channel's registers for the selected slot.
        always_comb begin
            rd = '0;
            case (reg_sel)
                REG_STATUS:   rd[1:0] = {run, to};
                REG_CONTROL:  rd[1:0] = {cont, ito};
                REG_PERIOD_L: rd = period[15:0];
                REG_PERIOD_H: rd[PH_W-1:0] = period[CNT_W-1:16];
                REG_SNAP_L:   rd = snap[15:0];
                REG_SNAP_H:   rd[PH_W-1:0] = snap[CNT_W-1:16];
                REG_PENDING:  rd[NUM_CH-1:0] = irq_ch;
`ifdef TIMER_BANK_PRESCALE_EN
                REG_PRESCALE: rd[7:0] = prescale;
`endif
                default:      rd = '0;
            endcase
        end

        assign rd_val[g] = rd;
    end

    for (genvar g = NUM_CH; g < 8; g++) begin : g_absent
        assign rd_val[g] = '0;
    end

    assign irq = |irq_ch;

    // Registered read data, refreshed every cycle from the addressed slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata <= '0;
        end else begin
            readdata <= rd_val[ch_sel];
        end
    end

endmodule

// File: tb/tb_qsys_system_timer_bank.sv
// Self-checking bench for qsys_system_timer_bank: a register-access vector
// table followed by directed multi-cycle timer sequences. Read expectations
// go through a scoreboard queue and are compared when readdata appears.
module tb_qsys_system_timer_bank;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int unsigned compared   = 0;
    int unsigned mismatched = 0;

    qsys_system_timer_bank #(
        .NUM_CH    (4),
        .CNT_W     (28),
        .RST_PERIOD(49999999)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_wr;
        logic [2:0]  ch;
        logic [2:0]  rg;
        logic [15:0] data;
        logic [15:0] exp;
    } vec_t;

    logic [15:0] sb_exp [$];
    string       sb_name[$];

    task automatic check(input logic [31:0] act, input logic [31:0] exp, input string name);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wr(input int ch, input int rg, input logic [15:0] d);
        address    = {3'(ch), 3'(rg)};
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input int ch, input int rg, input logic [15:0] exp, input string name);
        logic [15:0] e;
        string       nm;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        address    = {3'(ch), 3'(rg)};
        chipselect = 1'b1;
        write_n    = 1'b1;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        e  = sb_exp.pop_front();
        nm = sb_name.pop_front();
        check(32'(readdata), 32'(e), nm);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Counts clock edges until irq is seen, giving up after maxc edges.
    task automatic wait_irq(input int maxc, output int n);
        n = 0;
        while (irq !== 1'b1 && n < maxc) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    vec_t  tbl [19];
    string tbl_name [19];

    initial begin
        int n;

        tbl[0]  = '{1'b0, 3'd0, 3'd2, 16'h0000, 16'hF07F}; tbl_name[0]  = "rst period_l";
        tbl[1]  = '{1'b0, 3'd0, 3'd3, 16'h0000, 16'h02FA}; tbl_name[1]  = "rst period_h";
        tbl[2]  = '{1'b0, 3'd0, 3'd0, 16'h0000, 16'h0000}; tbl_name[2]  = "rst status";
        tbl[3]  = '{1'b0, 3'd3, 3'd1, 16'h0000, 16'h0000}; tbl_name[3]  = "rst control";
        tbl[4]  = '{1'b0, 3'd1, 3'd4, 16'h0000, 16'h0000}; tbl_name[4]  = "rst snap_l";
        tbl[5]  = '{1'b0, 3'd2, 3'd6, 16'h0000, 16'h0000}; tbl_name[5]  = "rst pending";
        tbl[6]  = '{1'b0, 3'd3, 3'd7, 16'h0000, 16'h0000}; tbl_name[6]  = "rst prescale";
        tbl[7]  = '{1'b1, 3'd5, 3'd2, 16'h1234, 16'h0000}; tbl_name[7]  = "";
        tbl[8]  = '{1'b0, 3'd5, 3'd2, 16'h0000, 16'h0000}; tbl_name[8]  = "oob period_l";
        tbl[9]  = '{1'b0, 3'd7, 3'd3, 16'h0000, 16'h0000}; tbl_name[9]  = "oob period_h";
        tbl[10] = '{1'b1, 3'd2, 3'd3, 16'hFFFF, 16'h0000}; tbl_name[10] = "";
        tbl[11] = '{1'b0, 3'd2, 3'd3, 16'h0000, 16'h0FFF}; tbl_name[11] = "period_h mask";
        tbl[12] = '{1'b1, 3'd2, 3'd2, 16'hABCD, 16'h0000}; tbl_name[12] = "";
        tbl[13] = '{1'b0, 3'd2, 3'd2, 16'h0000, 16'hABCD}; tbl_name[13] = "period_l rdbk";
        tbl[14] = '{1'b0, 3'd2, 3'd0, 16'h0000, 16'h0000}; tbl_name[14] = "status idle";
        tbl[15] = '{1'b1, 3'd3, 3'd1, 16'h000B, 16'h0000}; tbl_name[15] = "";
        tbl[16] = '{1'b0, 3'd3, 3'd1, 16'h0000, 16'h0003}; tbl_name[16] = "control rdbk";
        tbl[17] = '{1'b0, 3'd3, 3'd0, 16'h0000, 16'h0000}; tbl_name[17] = "stop no run";
        tbl[18] = '{1'b1, 3'd3, 3'd1, 16'h0000, 16'h0000}; tbl_name[18] = "";

        reset      = 1'b1;
        address    = '0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        #1;
        check(32'(readdata), 32'h0, "rst readdata");
        check(32'(irq), 32'h0, "rst irq");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check(32'(irq), 32'h0, "irq after rst");

        for (int i = 0; i < 19; i++) begin
            if (tbl[i].is_wr) begin
                wr(int'(tbl[i].ch), int'(tbl[i].rg), tbl[i].data);
            end else begin
                rd(int'(tbl[i].ch), int'(tbl[i].rg), tbl[i].exp, tbl_name[i]);
            end
        end

        // ch1 continuous, period 9: timeout every 10 cycles, RUN stays set.
        wr(1, 2, 16'd9);
        wr(1, 3, 16'd0);
        wr(1, 1, 16'h0007);
        wait_irq(40, n);
        check(32'(n + 1), 32'd10, "ch1 first timeout");
        for (int k = 0; k < 2; k++) begin
            wr(1, 0, 16'h0000);
            wait_irq(40, n);
            check(32'(n + 1), 32'd10, "ch1 interval");
        end
        rd(1, 0, 16'h0003, "ch1 run stays");
        wr(1, 1, 16'h0008);
        wr(1, 0, 16'h0000);
        check(32'(irq), 32'h0, "ch1 stopped irq");

        // ch2 one-shot, period 4.
        wr(2, 2, 16'd4);
        wr(2, 3, 16'd0);
        wr(2, 1, 16'h0005);
        wait_irq(40, n);
        check(32'(n + 1), 32'd5, "ch2 oneshot");
        idle(1);
        rd(2, 0, 16'h0001, "ch2 run cleared");
        wr(2, 4, 16'h0000);
        rd(2, 4, 16'h0004, "ch2 hold snap_l");
        rd(2, 5, 16'h0000, "ch2 hold snap_h");
        wr(2, 0, 16'h0000);
        idle(10);
        check(32'(irq), 32'h0, "ch2 no retrigger");
        wr(2, 1, 16'h0000);

        // ch0 (period 6) and ch3 (period 5) started one cycle apart so they
        // time out together; then a ch0 status write lands on its next timeout.
        wr(0, 2, 16'd6);
        wr(0, 3, 16'd0);
        wr(3, 2, 16'd5);
        wr(3, 3, 16'd0);
        wr(0, 1, 16'h0007);
        wr(3, 1, 16'h0007);
        check(32'(irq), 32'h0, "dual pre irq");
        idle(5);
        check(32'(irq), 32'h1, "dual irq");
        rd(0, 6, 16'h0009, "pending dual");
        idle(5);
        wr(0, 0, 16'h0000);
        rd(0, 0, 16'h0003, "ch0 to kept");
        wr(0, 0, 16'h0000);
        rd(0, 0, 16'h0002, "ch0 to cleared");
        rd(0, 6, 16'h0008, "pending ch3 only");
        wr(0, 1, 16'h0008);
        wr(3, 1, 16'h0008);
        wr(0, 0, 16'h0000);
        wr(3, 0, 16'h0000);
        check(32'(irq), 32'h0, "dual stopped irq");

        // ch1 snapshot of the live counter, then a period write mid-count.
        wr(1, 2, 16'h1240);
        wr(1, 3, 16'h0000);
        wr(1, 1, 16'h0006);
        idle(12);
        wr(1, 4, 16'h0000);
        rd(1, 4, 16'h1234, "snap_l live");
        rd(1, 5, 16'h0000, "snap_h live");
        rd(1, 0, 16'h0002, "ch1 running");
        wr(1, 2, 16'h0100);
        rd(1, 0, 16'h0000, "period wr stops");
        wr(1, 4, 16'h0000);
        rd(1, 4, 16'h0100, "period preload");

`ifdef TIMER_BANK_PRESCALE_EN
        // ch2 with P=3, period 1: one timeout every 8 cycles.
        wr(2, 7, 16'h0003);
        rd(2, 7, 16'h0003, "prescale rdbk");
        wr(2, 2, 16'd1);
        wr(2, 3, 16'd0);
        wr(2, 1, 16'h0007);
        wait_irq(40, n);
        check(32'(n + 1), 32'd5, "psc first timeout");
        for (int k = 0; k < 2; k++) begin
            wr(2, 0, 16'h0000);
            wait_irq(40, n);
            check(32'(n + 1), 32'd8, "psc interval");
        end
        wr(2, 1, 16'h0008);
        wr(2, 0, 16'h0000);
`else
        wr(2, 7, 16'h00FF);
        rd(2, 7, 16'h0000, "prescale ignored");
`endif

        rd(0, 6, 16'h0000, "final pending");
        check(32'(irq), 32'h0, "final irq");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
